// File: rtl/regfile_mp.sv
// Multi-port register file: x0 hardwired to zero, issue-time busy scoreboard,
// optional same-cycle write forwarding, sticky collision flag and saturating commit counter.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREG-1:0]     busy,
  output logic                err_multi,
  output logic [31:0]         wr_count
);

  logic [XLEN-1:0] regs_r [NREG];
  logic [NREG-1:0] busy_r;
  logic            err_multi_r;
  logic [31:0]     wr_count_r;

  logic [NWR-1:0]  live_s;
  logic [NWR-1:0]  shadow_s;
  logic [NWR-1:0]  win_s;
  logic            collide_s;
  logic [31:0]     n_commit_s;
  logic [NREG-1:0] busy_nxt_s;
  logic [32:0]     cnt_sum_s;
  logic [31:0]     cnt_nxt_s;
  logic [XLEN-1:0] word_s;

  // Write arbitration: a live port is shadowed by any higher-index live port to the same address
  always_comb begin
    live_s     = '0;
    shadow_s   = '0;
    n_commit_s = 32'd0;
    for (int j = 0; j < NWR; j++) begin
      live_s[j] = wr_en[j] & (wr_addr[j*AW +: AW] != '0);
    end
    for (int j = 0; j < NWR; j++) begin
      for (int i = j + 1; i < NWR; i++) begin
        shadow_s[j] = shadow_s[j] |
                      (live_s[i] & (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]));
      end
    end
    win_s     = live_s & ~shadow_s;
    collide_s = |(live_s & shadow_s);
    for (int j = 0; j < NWR; j++) begin
      n_commit_s = n_commit_s + {31'd0, win_s[j]};
    end
  end

  // Combinational read ports with optional forwarding of the winning write data
  always_comb begin
    rd_data = '0;
    word_s  = '0;
    for (int k = 0; k < NRD; k++) begin
      word_s = regs_r[rd_addr[k*AW +: AW]];
      for (int j = 0; j < NWR; j++) begin
        word_s = ((BYPASS != 0) && win_s[j] &&
                  (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])) ?
                 wr_data[j*XLEN +: XLEN] : word_s;
      end
      word_s = (i_rst || (rd_addr[k*AW +: AW] == '0)) ? '0 : word_s;
      rd_data[k*XLEN +: XLEN] = word_s;
    end
  end

  // Next busy vector: commits clear first so a same-edge reservation wins
  always_comb begin
    busy_nxt_s = busy_r;
    for (int j = 0; j < NWR; j++) begin
      busy_nxt_s[wr_addr[j*AW +: AW]] = win_s[j] ? 1'b0 : busy_nxt_s[wr_addr[j*AW +: AW]];
    end
    busy_nxt_s[rsv_addr] = rsv_en ? 1'b1 : busy_nxt_s[rsv_addr];
    busy_nxt_s[0]        = 1'b0;
  end

  // Saturating commit counter
  always_comb begin
    cnt_sum_s = {1'b0, wr_count_r} + {1'b0, n_commit_s};
    cnt_nxt_s = cnt_sum_s[32] ? 32'hFFFF_FFFF : cnt_sum_s[31:0];
  end

  // State update; register 0 is never written so it stays at its reset value of zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_r[r] <= '0;
      end
      busy_r      <= '0;
      err_multi_r <= 1'b0;
      wr_count_r  <= 32'd0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (win_s[j]) begin
          regs_r[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
      busy_r      <= busy_nxt_s;
      err_multi_r <= err_multi_r | collide_s;
      wr_count_r  <= cnt_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign err_multi = err_multi_r;
  assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default (bypass on/off) and a swept-parameter instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instances share stimulus
  logic [9:0]  rd_addr  = '0;
  logic [1:0]  wr_en    = '0;
  logic [9:0]  wr_addr  = '0;
  logic [63:0] wr_data  = '0;
  logic        rsv_en   = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic [63:0] a_rd, b_rd;
  logic [31:0] a_busy, b_busy, a_cnt, b_cnt;
  logic        a_err, b_err;

  // swept instance: NREG=16, XLEN=64, NRD=3, NWR=1
  logic [11:0]  c_rd_addr  = '0;
  logic [0:0]   c_wr_en    = '0;
  logic [3:0]   c_wr_addr  = '0;
  logic [63:0]  c_wr_data  = '0;
  logic         c_rsv_en   = 1'b0;
  logic [3:0]   c_rsv_addr = '0;
  logic [191:0] c_rd;
  logic [15:0]  c_busy;
  logic         c_err;
  logic [31:0]  c_cnt;

  regfile_mp #(.BYPASS(1)) dut_a (
    .i_clk(clk), .i_rst(i_rst), .rd_addr(rd_addr), .rd_data(a_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy(a_busy), .err_multi(a_err), .wr_count(a_cnt));

  regfile_mp #(.BYPASS(0)) dut_b (
    .i_clk(clk), .i_rst(i_rst), .rd_addr(rd_addr), .rd_data(b_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy(b_busy), .err_multi(b_err), .wr_count(b_cnt));

  regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1)) dut_c (
    .i_clk(clk), .i_rst(i_rst), .rd_addr(c_rd_addr), .rd_data(c_rd),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .rsv_en(c_rsv_en), .rsv_addr(c_rsv_addr),
    .busy(c_busy), .err_multi(c_err), .wr_count(c_cnt));

  typedef struct {
    int          sel;
    int          idx;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // reference model state
  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  logic        m_err;
  logic [63:0] m_cnt;
  logic [63:0] c_reg [16];
  logic [15:0] c_mbusy;
  logic [63:0] c_mcnt;

  function automatic void expect_val(int sel, int idx, logic [63:0] exp, string name);
    chk_t e;
    e.sel = sel; e.idx = idx; e.exp = exp; e.name = name;
    sbq.push_back(e);
  endfunction

  function automatic logic [63:0] actual(int sel, int idx);
    case (sel)
      0: return {32'd0, a_rd[idx*32 +: 32]};
      1: return {32'd0, b_rd[idx*32 +: 32]};
      2: return {32'd0, a_busy};
      3: return {63'd0, a_err};
      4: return {32'd0, a_cnt};
      5: return c_rd[idx*64 +: 64];
      6: return {48'd0, c_busy};
      7: return {32'd0, c_cnt};
      default: return '1;
    endcase
  endfunction

  // monitor: compare every queued expectation against the outputs presented this cycle
  always @(negedge clk) begin
    chk_t e;
    logic [63:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      act = actual(e.sel, e.idx);
      n_checks++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s[%0d]: got %h expected %h at %0t", e.name, e.idx, act, e.exp, $time);
      end
    end
  end

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
    for (int r = 0; r < 16; r++) c_reg[r] = 64'd0;
    m_busy = 32'd0; m_err = 1'b0; m_cnt = 64'd0;
    c_mbusy = 16'd0; c_mcnt = 64'd0;
  endfunction

  function automatic void push_state_a();
    expect_val(2, 0, {32'd0, m_busy}, "a_busy");
    expect_val(3, 0, {63'd0, m_err}, "a_err");
    expect_val(4, 0, m_cnt, "a_cnt");
  endfunction

  // one cycle on the default instances; call at posedge+1, returns at next posedge+1
  task automatic step(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                      input logic [31:0] wd0, input logic [31:0] wd1,
                      input logic re, input logic [4:0] ra,
                      input logic [4:0] r0, input logic [4:0] r1);
    logic [31:0] wmap [int];
    logic        coll;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [4:0]  rk [2];
    logic [31:0] ea, eb;
    wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; rk[0] = r0; rk[1] = r1;
    wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    rsv_en = re; rsv_addr = ra; rd_addr = {r1, r0};
    coll = 1'b0;
    for (int j = 0; j < 2; j++) begin
      if (we[j] && wa[j] != 5'd0) begin
        if (wmap.exists(int'(wa[j]))) coll = 1'b1;
        wmap[int'(wa[j])] = wd[j];
      end
    end
    for (int k = 0; k < 2; k++) begin
      eb = (rk[k] == 5'd0) ? 32'd0 : m_reg[rk[k]];
      ea = wmap.exists(int'(rk[k])) ? wmap[int'(rk[k])] : eb;
      expect_val(0, k, {32'd0, ea}, "a_rd");
      expect_val(1, k, {32'd0, eb}, "b_rd");
    end
    push_state_a();
    @(posedge clk); #1;
    foreach (wmap[a]) begin
      m_reg[a] = wmap[a];
      m_busy[a] = 1'b0;
    end
    m_cnt = m_cnt + 64'(wmap.num());
    if (m_cnt > 64'h0000_0000_FFFF_FFFF) m_cnt = 64'h0000_0000_FFFF_FFFF;
    if (coll) m_err = 1'b1;
    if (re && ra != 5'd0) m_busy[ra] = 1'b1;
  endtask

  // one cycle on the swept instance
  task automatic step_c(input logic we, input logic [3:0] wa, input logic [63:0] wd,
                        input logic re, input logic [3:0] ra,
                        input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    logic [3:0]  rk [3];
    logic [63:0] ev;
    rk[0] = r0; rk[1] = r1; rk[2] = r2;
    c_wr_en = we; c_wr_addr = wa; c_wr_data = wd;
    c_rsv_en = re; c_rsv_addr = ra; c_rd_addr = {r2, r1, r0};
    for (int k = 0; k < 3; k++) begin
      if (rk[k] == 4'd0) ev = 64'd0;
      else if (we && wa == rk[k]) ev = wd;
      else ev = c_reg[rk[k]];
      expect_val(5, k, ev, "c_rd");
    end
    expect_val(6, 0, {48'd0, c_mbusy}, "c_busy");
    expect_val(7, 0, c_mcnt, "c_cnt");
    @(posedge clk); #1;
    if (we && wa != 4'd0) begin
      c_reg[wa] = wd;
      c_mbusy[wa] = 1'b0;
      c_mcnt = (c_mcnt >= 64'h0000_0000_FFFF_FFFF) ? c_mcnt : c_mcnt + 64'd1;
    end
    if (re && ra != 4'd0) c_mbusy[ra] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #1 i_rst = 1'b1;
    rd_addr = {5'd5, 5'd1};
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) expect_val(0, k, 64'd0, "rst_a_rd");
    push_state_a();
    expect_val(6, 0, 64'd0, "rst_c_busy");
    expect_val(7, 0, 64'd0, "rst_c_cnt");
    @(posedge clk); #1;
    i_rst = 1'b0;

    // dual write, bypassed read then committed read
    step(2'b11, 5'd5, 5'd6, 32'h11, 32'h22, 1'b0, 5'd0, 5'd5, 5'd6);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    // collision on x7: highest port wins, counts once, sets err
    step(2'b11, 5'd7, 5'd7, 32'hAA, 32'hBB, 1'b0, 5'd0, 5'd7, 5'd7);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5);
    // forwarding versus pre-edge contents
    step(2'b01, 5'd3, 5'd0, 32'h55, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    // scoreboard: reserve, commit, same-edge reserve+commit
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd3, 5'd9);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    step(2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    step(2'b10, 5'd0, 5'd9, 32'h0, 32'h77, 1'b1, 5'd9, 5'd9, 5'd0);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    // x0: write and reserve ignored
    step(2'b01, 5'd0, 5'd0, 32'hFF, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);

    for (int n = 0; n < 80; n++) begin
      step(2'($urandom_range(0, 3)), 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
           32'($urandom()), 32'($urandom()), 1'($urandom_range(0, 3) == 0),
           5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
    end

    // saturation of the commit counter
    force dut_a.wr_count_r = 32'hFFFF_FFFE;
    #1 release dut_a.wr_count_r;
    m_cnt = 64'h0000_0000_FFFF_FFFE;
    step(2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 1'b0, 5'd0, 5'd1, 5'd2);
    step(2'b01, 5'd3, 5'd0, 32'h3, 32'h0, 1'b0, 5'd0, 5'd3, 5'd1);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd10, 5'd1, 5'd3);

    // reset mid-cycle while writes are presented
    wr_en = 2'b11; wr_addr = {5'd4, 5'd3}; wr_data = {32'h4444, 32'h3333};
    rsv_en = 1'b1; rsv_addr = 5'd11; rd_addr = {5'd4, 5'd3};
    #2 i_rst = 1'b1;
    #1;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      expect_val(0, k, 64'd0, "rst_mid_a_rd");
      expect_val(1, k, 64'd0, "rst_mid_b_rd");
    end
    push_state_a();
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) expect_val(0, k, 64'd0, "rst_hold_a_rd");
    push_state_a();
    @(posedge clk); #1;
    i_rst = 1'b0;
    step(2'b01, 5'd3, 5'd0, 32'h1234, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    wr_en = 2'b00; rsv_en = 1'b0;

    // swept-parameter instance
    step_c(1'b1, 4'd5, 64'hDEAD_0000_0000_0011, 1'b0, 4'd0, 4'd5, 4'd6, 4'd0);
    step_c(1'b1, 4'd6, 64'hBEEF_0000_0000_0022, 1'b0, 4'd0, 4'd5, 4'd6, 4'd0);
    step_c(1'b0, 4'd0, 64'd0, 1'b1, 4'd9, 4'd5, 4'd6, 4'd9);
    step_c(1'b1, 4'd9, 64'hCAFE_0000_0000_0099, 1'b0, 4'd0, 4'd9, 4'd5, 4'd6);
    step_c(1'b1, 4'd9, 64'h1111_2222_3333_4444, 1'b1, 4'd9, 4'd9, 4'd0, 4'd6);
    step_c(1'b1, 4'd0, 64'hFF, 1'b1, 4'd0, 4'd0, 4'd9, 4'd15);
    step_c(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 4'd0, 4'd9, 4'd5);

    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
